// File: rtl/timing_control_unit_pkg.sv
// Shared constants for the timing control unit: sequence-counter sizing,
// symbolic timing indices and the register/IO-reference opcode.
package timing_control_unit_pkg;
  localparam int SC_W = 4;
  localparam int T_W  = 16;

  localparam int T_FETCH0 = 0;
  localparam int T_FETCH1 = 1;
  localparam int T_DECODE = 2;

  localparam logic [2:0] OP_D7 = 3'b111;
endpackage

// File: rtl/decoder_3x8.sv
// Combinational 3-to-8 one-hot decoder.
module decoder_3x8 (
  input  logic [2:0] i_sel,
  output logic [7:0] o_y
);
  always_comb begin
    o_y        = '0;
    o_y[i_sel] = 1'b1;
  end
endmodule

// File: rtl/timing_control_unit.sv
// Sequence counter, run flag and interrupt-cycle control producing the
// one-hot T timing signals and the opcode decode D/I.
module timing_control_unit #(
  parameter int SC_W = timing_control_unit_pkg::SC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hlt,
  input  logic                 sc_clr,
  input  logic [15:0]          ir,
  input  logic                 fgi,
  input  logic                 fgo,
  input  logic                 ien_set,
  input  logic                 ien_clr,
  output logic [2**SC_W-1:0]   T,
  output logic [7:0]           D,
  output logic                 I,
  output logic                 R,
  output logic                 ien,
  output logic                 running,
  output logic                 sc_err
);
  import timing_control_unit_pkg::*;

  localparam int TW = 2**SC_W;

  logic [SC_W-1:0] r_sc;
  logic            r_running;
  logic            r_r;
  logic            r_ien;
  logic            r_sc_err;

  logic [TW-1:0]   w_t;
  logic            w_int_end;
  logic            w_r_set;
  logic            w_sc_max;

  decoder_3x8 u_dec (
    .i_sel (ir[14:12]),
    .o_y   (D)
  );

  assign I = ir[15];

  always_comb begin
    w_t = '0;
    if (r_running) w_t[r_sc] = 1'b1;
  end

  // hlt outranks both ending and starting an interrupt cycle
  assign w_int_end = r_running & ~hlt & r_r & w_t[T_DECODE];
  assign w_r_set   = r_running & ~hlt & ~w_t[T_FETCH0] & ~w_t[T_FETCH1] &
                     ~w_t[T_DECODE] & r_ien & (fgi | fgo);
  assign w_sc_max  = &r_sc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc      <= '0;
      r_running <= 1'b0;
      r_r       <= 1'b0;
      r_ien     <= 1'b0;
      r_sc_err  <= 1'b0;
    end else begin
      if (!r_running) begin
        if (start && !hlt) begin
          r_running <= 1'b1;
          r_sc      <= '0;
        end
      end else if (hlt) begin
        r_running <= 1'b0;
        r_sc      <= '0;
      end else if (w_int_end) begin
        r_r  <= 1'b0;
        r_sc <= '0;
      end else if (sc_clr && !r_r) begin
        r_sc <= '0;
      end else begin
        r_sc <= r_sc + SC_W'(1);
        if (w_sc_max) r_sc_err <= 1'b1;
      end

      if (w_r_set) r_r <= 1'b1;

      if (ien_clr || w_int_end) r_ien <= 1'b0;
      else if (ien_set)         r_ien <= 1'b1;
    end
  end

  assign T       = w_t;
  assign R       = r_r;
  assign ien     = r_ien;
  assign running = r_running;
  assign sc_err  = r_sc_err;
endmodule

// File: tb/tb_timing_control_unit.sv
// Scoreboard bench: driver steps a behavioural model and queues expectations,
// monitor compares DUT outputs one cycle later.
module tb_timing_control_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, hlt = 1'b0, sc_clr = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        fgi = 1'b0, fgo = 1'b0, ien_set = 1'b0, ien_clr = 1'b0;
  logic [15:0] T;
  logic [7:0]  D;
  logic        I, R, ien, running, sc_err;

  timing_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .sc_clr(sc_clr), .ir(ir),
    .fgi(fgi), .fgo(fgo), .ien_set(ien_set), .ien_clr(ien_clr),
    .T(T), .D(D), .I(I), .R(R), .ien(ien), .running(running), .sc_err(sc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    logic [7:0]  d;
    logic        i, r, ien, run, err;
    bit          fix;
    logic [15:0] tfix;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 0;

  // behavioural model state
  int m_sc = 0;
  bit m_run = 0, m_r = 0, m_ien = 0, m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rs, st, hl, sc, fi, fo, es, ec,
                      input logic [15:0] irv, input bit fx, input logic [15:0] tf);
    exp_t e;
    bit   n_run, n_r, n_ien, n_err;
    int   n_sc;
    @(negedge clk);
    rst = rs; start = st; hlt = hl; sc_clr = sc; fgi = fi; fgo = fo;
    ien_set = es; ien_clr = ec; ir = irv;
    n_sc = m_sc; n_run = m_run; n_r = m_r; n_err = m_err;
    n_ien = ec ? 1'b0 : (es ? 1'b1 : m_ien);
    if (rs) begin
      n_sc = 0; n_run = 0; n_r = 0; n_ien = 0; n_err = 0;
    end else begin
      if (!m_run) begin
        if (st && !hl) begin n_run = 1; n_sc = 0; end
      end else if (hl) begin
        n_run = 0; n_sc = 0;
      end else if (m_r && m_sc == 2) begin
        n_r = 0; n_ien = 0; n_sc = 0;
      end else if (sc && !m_r) begin
        n_sc = 0;
      end else begin
        n_sc = (m_sc + 1) % 16;
        if (m_sc == 15) n_err = 1;
      end
      if (m_run && !hl && m_sc > 2 && m_ien && (fi || fo)) n_r = 1;
    end
    m_sc = n_sc; m_run = n_run; m_r = n_r; m_ien = n_ien; m_err = n_err;
    e.t    = m_run ? (16'h0001 << m_sc) : 16'h0000;
    e.d    = 8'h01 << irv[14:12];
    e.i    = irv[15];
    e.r    = m_r;
    e.ien  = m_ien;
    e.run  = m_run;
    e.err  = m_err;
    e.fix  = fx;
    e.tfix = tf;
    q.push_back(e);
  endtask

  task automatic idle(input logic [15:0] irv, input bit fx, input logic [15:0] tf);
    step(0, 0, 0, 0, 0, 0, 0, 0, irv, fx, tf);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("T", 32'(T), 32'(e.t));
        chk("D", 32'(D), 32'(e.d));
        chk("I", 32'(I), 32'(e.i));
        chk("R", 32'(R), 32'(e.r));
        chk("ien", 32'(ien), 32'(e.ien));
        chk("running", 32'(running), 32'(e.run));
        chk("sc_err", 32'(sc_err), 32'(e.err));
        if (e.fix) chk("T_directed", 32'(T), 32'(e.tfix));
      end
    end
  end

  initial begin
    // reset, then start: T0..T3
    step(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000);
    step(0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0001);
    idle(16'h0000, 1, 16'h0002);
    idle(16'h0000, 1, 16'h0004);
    idle(16'h7000, 1, 16'h0008);
    // register-reference instruction completes at T3
    step(0, 0, 0, 1, 0, 0, 0, 0, 16'h7123, 1, 16'h0001);
    // enable interrupts, flag at T4 alongside sc_clr -> interrupt cycle
    step(0, 0, 0, 0, 0, 0, 1, 0, 16'h7123, 1, 16'h0002);
    idle(16'h7123, 1, 16'h0004);
    idle(16'h7123, 1, 16'h0008);
    idle(16'h7123, 1, 16'h0010);
    step(0, 0, 0, 1, 1, 0, 0, 0, 16'h7123, 1, 16'h0001);
    idle(16'h7123, 1, 16'h0002);
    step(0, 0, 0, 1, 0, 0, 0, 0, 16'h7123, 1, 16'h0004);
    idle(16'h7123, 1, 16'h0001);
    // 16 cycles with no sc_clr wraps and sets sc_err
    for (int k = 1; k <= 16; k++) idle(16'hA5C3, 1, 16'h0001 << (k % 16));
    // hlt + start + sc_clr at T5
    for (int k = 1; k <= 5; k++) idle(16'h3000, 1, 16'h0001 << k);
    step(0, 1, 1, 1, 0, 0, 0, 0, 16'h3000, 1, 16'h0000);
    idle(16'h3000, 1, 16'h0000);
    step(0, 1, 0, 0, 0, 0, 0, 0, 16'h3000, 1, 16'h0001);
    // reset during RT1
    step(0, 0, 0, 0, 0, 0, 1, 0, 16'h8000, 1, 16'h0002);
    idle(16'h8000, 1, 16'h0004);
    idle(16'h8000, 1, 16'h0008);
    step(0, 0, 0, 1, 0, 1, 0, 0, 16'h8000, 1, 16'h0001);
    idle(16'h8000, 1, 16'h0002);
    step(1, 0, 0, 0, 0, 0, 0, 0, 16'h8000, 1, 16'h0000);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0),
           16'($urandom), 0, 16'h0000);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
